// File: rtl/array_wframe_buf_if.sv
// array_wframe_buf_if
// Bundles the write-frame buffer's traffic: upstream beat handshake, the
// show-ahead head toward array_write, burst start/done, and status/error.
//   slave  : the buffer side (array_wframe_buf)
//   master : the environment side (command path + array_write + status)
`timescale 1ns/1ps
interface array_wframe_buf_if #(
    parameter int unsigned FRAME_W = 89,
    parameter int unsigned FIFO_AW = 5
);
    logic               in_wframe_valid;
    logic [FRAME_W-1:0] in_wframe_data;
    logic               in_wframe_ready;
    logic               array_wframe_valid;
    logic [FRAME_W-1:0] array_wframe_data;
    logic               array_wframe_ready;
    logic               array_wr_start;
    logic               array_wr_done;
    logic [FIFO_AW:0]   fifo_level;
    logic [FIFO_AW:0]   frame_cnt;
    logic               err_proto;
    logic               err_clr;

    modport slave (
        input  in_wframe_valid, in_wframe_data, array_wframe_ready,
               array_wr_done, err_clr,
        output in_wframe_ready, array_wframe_valid, array_wframe_data,
               array_wr_start, fifo_level, frame_cnt, err_proto
    );

    modport master (
        output in_wframe_valid, in_wframe_data, array_wframe_ready,
               array_wr_done, err_clr,
        input  in_wframe_ready, array_wframe_valid, array_wframe_data,
               array_wr_start, fifo_level, frame_cnt, err_proto
    );
endinterface

// File: rtl/array_wframe_buf.sv
// array_wframe_buf
// Show-ahead FIFO of write-frame beats feeding array_write. Issues one
// array_wr_start pulse per buffered burst (complete frame present, or FIFO
// full so an overlong burst drains cut-through) and waits for array_wr_done
// before the next one.
// Optional feature macro: ARRAY_WFRAME_BUF_PROTO_CHECK_EN -- drop malformed
// beats (stray sof/continuation, read-flagged beats) and flag err_proto.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : array_wframe_buf_if.slave (in_wframe_*, array_wframe_*,
//          array_wr_start/done, fifo_level, frame_cnt, err_proto, err_clr)
// Frame layout: [eof | sof | rw_flag | data | row | col]
`timescale 1ns/1ps
module array_wframe_buf #(
    parameter int unsigned ARRAY_COL_ADDR_WIDTH   = 6,
    parameter int unsigned ARRAY_ROW_ADDR_WIDTH   = 16,
    parameter int unsigned ARRAY_DATA_WIDTH       = 64,
    parameter int unsigned ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH
                                                  + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH,
    parameter int unsigned FIFO_AW                = 5
) (
    input logic              clk,
    input logic              rst,
    array_wframe_buf_if.slave bus
);
    localparam int unsigned FW      = ARRAY_FRAME_DATA_WIDTH;
    localparam int unsigned CW      = FIFO_AW + 1;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned EOF_BIT = FW - 1;
    localparam int unsigned SOF_BIT = FW - 2;
    localparam int unsigned RW_BIT  = FW - 3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

    logic [FW-1:0]      mem [DEPTH];
    logic [CW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      level_q, frame_cnt_q;
    logic               err_q;
    logic               wr_start_q;
    state_t             state_q;

    logic               full_c, empty_c, accept_c, push_c, pop_c, drop_c;
    logic               push_eof_c, pop_eof_c;
    logic [FW-1:0]      head_c;

    // FIFO status from wrap-bit pointers
    assign full_c  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign head_c  = mem[rd_ptr[FIFO_AW-1:0]];

    assign accept_c   = bus.in_wframe_valid & bus.in_wframe_ready;
    assign pop_c      = bus.array_wframe_ready & ~empty_c;
    assign push_c     = accept_c & ~drop_c;
    assign push_eof_c = push_c & bus.in_wframe_data[EOF_BIT];
    assign pop_eof_c  = pop_c & head_c[EOF_BIT];

`ifdef ARRAY_WFRAME_BUF_PROTO_CHECK_EN
    logic in_frame_q;
    logic bad_c;

    // Malformed: continuation with no open frame, new sof inside a frame, or a read beat
    assign bad_c  = (~bus.in_wframe_data[SOF_BIT] & ~in_frame_q) |
                    ( bus.in_wframe_data[SOF_BIT] &  in_frame_q) |
                    ~bus.in_wframe_data[RW_BIT];
    assign drop_c = accept_c & bad_c;

    // Open-frame tracker, advanced only by beats that are actually stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q <= 1'b0;
        end else if (push_c) begin
            if (bus.in_wframe_data[EOF_BIT])      in_frame_q <= 1'b0;
            else if (bus.in_wframe_data[SOF_BIT]) in_frame_q <= 1'b1;
        end
    end
`else
    assign drop_c = 1'b0;
`endif

    // Storage: contents are not reset, only the pointers
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[FIFO_AW-1:0]] <= bus.in_wframe_data;
    end

    // Pointers and occupancy counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + CW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + CW'(1);
            if (push_c && !pop_c)      level_q <= level_q + CW'(1);
            else if (!push_c && pop_c) level_q <= level_q - CW'(1);
            if (push_eof_c && !pop_eof_c)      frame_cnt_q <= frame_cnt_q + CW'(1);
            else if (!push_eof_c && pop_eof_c) frame_cnt_q <= frame_cnt_q - CW'(1);
        end
    end

    // Sticky error; a new error in the same cycle as err_clr wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              err_q <= 1'b0;
        else if (drop_c)      err_q <= 1'b1;
        else if (bus.err_clr) err_q <= 1'b0;
    end

    // Burst start FSM: one burst in flight, released by array_wr_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_start_q <= 1'b0;
        end else begin
            wr_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if ((frame_cnt_q != '0) || full_c) begin
                        state_q    <= S_START;
                        wr_start_q <= 1'b1;
                    end
                end
                S_START: state_q <= S_BUSY;
                S_BUSY:  if (bus.array_wr_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_wframe_ready    = ~full_c & ~rst;
    assign bus.array_wframe_valid = ~empty_c;
    assign bus.array_wframe_data  = empty_c ? '0 : head_c;
    assign bus.array_wr_start     = wr_start_q;
    assign bus.fifo_level         = level_q;
    assign bus.frame_cnt          = frame_cnt_q;
    assign bus.err_proto          = err_q;
endmodule
